// File: rtl/datapath_seq_pkg.sv
// ============================================================================
// Module      : datapath_seq_pkg
// Description : Shared state encoding, opcode constants and register-select
//               bit indices for the datapath sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package datapath_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_WAIT   = 3'd3,
    ST_EXEC   = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_e;

  localparam logic [3:0] OP_MUL          = 4'hA;
  localparam logic [3:0] OP_DIV          = 4'hB;
  localparam logic [3:0] OP_ILLEGAL_BASE = 4'hC;

  localparam int unsigned SEL_RA = 0;
  localparam int unsigned SEL_RB = 1;
  localparam int unsigned SEL_RZ = 2;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return (op >= OP_ILLEGAL_BASE);
  endfunction

  function automatic logic op_is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/datapath_sequencer_wait_counter.sv
// ============================================================================
// Module      : seq_wait_counter
// Description : Loadable 4-bit down-counter; done flags the final wait cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_wait_counter (
  input  logic       clock,
  input  logic       clear,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic       done_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // A zero count also reports done so a stray WAIT entry can never stall.
  assign done_o = (count_q <= 4'd1);

endmodule

`default_nettype wire

// File: rtl/datapath_sequencer.sv
// ============================================================================
// Module      : datapath_sequencer
// Description : Drives a register/ALU datapath through load-A, load-B,
//               optional MUL/DIV settle, execute, and response handshake.
//               Optional DATAPATH_SEQ_OP_COUNT_EN adds the op_count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module datapath_sequencer
  import datapath_seq_pkg::*;
#(
  parameter int unsigned MULDIV_WAIT = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_result,
  output logic        resp_error,
  output logic [3:0]  op_select,
  output logic [15:0] register_select,
  output logic [31:0] register_in,
  input  logic [63:0] rz_data
`ifdef DATAPATH_SEQ_OP_COUNT_EN
  ,
  output logic [31:0] op_count
`endif
);

  localparam logic [3:0] WAIT_LOAD = 4'(MULDIV_WAIT);

  seq_state_e  state_q, state_d;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        err_q;
  logic [63:0] result_q, result_d;
  logic        accept;
  logic        wait_done;

  assign accept = req_valid && (state_q == ST_IDLE);

  seq_wait_counter u_wait_counter (
    .clock      (clock),
    .clear      (clear),
    .load_i     ((state_q == ST_LOAD_B) && op_is_muldiv(op_q)),
    .load_val_i (WAIT_LOAD),
    .en_i       (state_q == ST_WAIT),
    .done_o     (wait_done)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = op_is_illegal(req_op) ? ST_DONE : ST_LOAD_A;
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_LOAD_B: state_d = op_is_muldiv(op_q) ? ST_WAIT : ST_EXEC;
      ST_WAIT:   if (wait_done) state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_DONE;
      ST_DONE:   if (resp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready       = (state_q == ST_IDLE);
    resp_valid      = (state_q == ST_DONE);
    resp_error      = (state_q == ST_DONE) && err_q;
    resp_result     = result_q;
    op_select       = 4'd0;
    register_select = 16'd0;
    register_in     = 32'd0;
    case (state_q)
      ST_LOAD_A: begin
        op_select               = op_q;
        register_select[SEL_RA] = 1'b1;
        register_in             = a_q;
      end
      ST_LOAD_B: begin
        op_select               = op_q;
        register_select[SEL_RB] = 1'b1;
        register_in             = b_q;
      end
      ST_WAIT: op_select = op_q;
      ST_EXEC: begin
        op_select               = op_q;
        register_select[SEL_RZ] = 1'b1;
      end
      default: ;
    endcase
  end

  // rz is captured on the edge into DONE; illegal requests reach DONE from IDLE.
  always_comb begin
    result_d = result_q;
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      result_d = (state_q == ST_IDLE) ? 64'd0 : rz_data;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      op_q     <= 4'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      err_q    <= 1'b0;
      result_q <= 64'd0;
    end else begin
      result_q <= result_d;
      if (accept) begin
        op_q  <= req_op;
        a_q   <= req_a;
        b_q   <= req_b;
        err_q <= op_is_illegal(req_op);
      end
    end
  end

`ifdef DATAPATH_SEQ_OP_COUNT_EN
  logic [31:0] op_count_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      op_count_q <= 32'd0;
    end else if (resp_valid && resp_ready) begin
      op_count_q <= op_count_q + 32'd1;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
// ============================================================================
// Module      : tb_datapath_sequencer
// Description : Randomized self-checking bench with a behavioural datapath
//               and latency/strobe-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_datapath_sequencer;

  localparam int unsigned W = 4;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        req_valid = 1'b0;
  logic        resp_ready = 1'b0;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        req_ready, resp_valid, resp_error;
  logic [63:0] resp_result;
  logic [3:0]  op_select;
  logic [15:0] register_select;
  logic [31:0] register_in;
  logic [63:0] rz_data;
  logic [31:0] ra_m = 32'd0;
  logic [31:0] rb_m = 32'd0;
`ifdef DATAPATH_SEQ_OP_COUNT_EN
  logic [31:0] op_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  datapath_sequencer #(.MULDIV_WAIT(W)) dut (
    .clock           (clock),
    .clear           (clear),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_a           (req_a),
    .req_b           (req_b),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_result     (resp_result),
    .resp_error      (resp_error),
    .op_select       (op_select),
    .register_select (register_select),
    .register_in     (register_in),
    .rz_data         (rz_data)
`ifdef DATAPATH_SEQ_OP_COUNT_EN
    ,
    .op_count        (op_count)
`endif
  );

  function automatic logic [63:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h0:    return 64'(a) + 64'(b);
      4'h1:    return {32'd0, a - b};
      4'h2:    return {32'd0, a & b};
      4'h3:    return {32'd0, a | b};
      4'h4:    return {32'd0, a ^ b};
      4'hA:    return 64'(a) * 64'(b);
      4'hB:    return (b == 32'd0) ? 64'd0 : {a % b, a / b};
      default: return {a, b};
    endcase
  endfunction

  // Behavioural datapath: RA/RB load on strobes, rz reflects the selected ALU op.
  always @(posedge clock) begin
    if (register_select[0]) ra_m <= register_in;
    if (register_select[1]) rb_m <= register_in;
  end
  always_comb rz_data = alu(op_select, ra_m, rb_m);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic        illegal;
    logic        md;
    int          lat;
    logic [31:0] ra0, rb0;
    logic [63:0] exp_res;
    logic [15:0] e_sel;
    logic [31:0] e_in;
    logic [3:0]  e_op;
    illegal = (op >= 4'hC);
    md      = (op == 4'hA) || (op == 4'hB);
    lat     = illegal ? 1 : (md ? 4 + int'(W) : 4);
    ra0     = ra_m;
    rb0     = rb_m;
    exp_res = illegal ? 64'd0 : alu(op, a, b);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; resp_ready = 1'b0;
    check("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clock);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clock);
      req_valid = 1'($urandom_range(0, 1));
      req_op = 4'($urandom); req_a = $urandom; req_b = $urandom;
      e_sel = 16'd0; e_in = 32'd0; e_op = (k < lat) ? op : 4'd0;
      if (k == lat)          begin e_sel = 16'd0; end
      else if (k == 1)       begin e_sel = 16'h0001; e_in = a; end
      else if (k == 2)       begin e_sel = 16'h0002; e_in = b; end
      else if (k == lat - 1) begin e_sel = 16'h0004; end
      check("register_select", 64'(register_select), 64'(e_sel));
      if (e_sel != 16'h0004) check("register_in", 64'(register_in), 64'(e_in));
      check("op_select", 64'(op_select), 64'(e_op));
      check("req_ready_busy", 64'(req_ready), 64'd0);
      check("resp_valid_timing", 64'(resp_valid), 64'(k == lat));
    end
    check("resp_error", 64'(resp_error), 64'(illegal));
    check("resp_result", resp_result, exp_res);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      req_valid = 1'b1; req_op = 4'($urandom);
      check("hold_resp_valid", 64'(resp_valid), 64'd1);
      check("hold_resp_result", resp_result, exp_res);
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0; req_valid = 1'b0;
    check("post_resp_valid", 64'(resp_valid), 64'd0);
    check("post_req_ready", 64'(req_ready), 64'd1);
    if (illegal) begin
      check("illegal_ra_untouched", 64'(ra_m), 64'(ra0));
      check("illegal_rb_untouched", 64'(rb_m), 64'(rb0));
    end
  endtask

  initial begin
    #12;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_error", 64'(resp_error), 64'd0);
    check("rst_resp_result", resp_result, 64'd0);
    check("rst_op_select", 64'(op_select), 64'd0);
    check("rst_register_select", 64'(register_select), 64'd0);
    check("rst_register_in", 64'(register_in), 64'd0);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    check("rst_req_ready", 64'(req_ready), 64'd1);

    run_txn(4'h0, 32'd5, 32'd7, 0);
    run_txn(4'hA, 32'h0001_2345, 32'h0000_BEEF, 0);
    run_txn(4'hB, 32'd1000, 32'd7, 1);
    run_txn(4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    run_txn(4'h4, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 10);
    for (int i = 0; i < 40; i++) begin
      run_txn(4'($urandom_range(0, 15)), $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    // Abandon a MUL while it sits in WAIT.
    req_valid = 1'b1; req_op = 4'hA; req_a = 32'd3; req_b = 32'd9;
    @(posedge clock);
    @(negedge clock); req_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("wait_strobe_zero", 64'(register_select), 64'd0);
    check("wait_op_select", 64'(op_select), 64'hA);
    #2 clear = 1'b0;
    #1;
    check("clr_op_select", 64'(op_select), 64'd0);
    check("clr_register_select", 64'(register_select), 64'd0);
    check("clr_register_in", 64'(register_in), 64'd0);
    check("clr_resp_valid", 64'(resp_valid), 64'd0);
    check("clr_resp_result", resp_result, 64'd0);
    @(negedge clock);
    clear = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      check("abandon_no_resp", 64'(resp_valid), 64'd0);
      check("abandon_no_strobe", 64'(register_select), 64'd0);
    end
    run_txn(4'h0, 32'hFFFF_FFFF, 32'd1, 0);

`ifdef DATAPATH_SEQ_OP_COUNT_EN
    dut.op_count_q = 32'hFFFF_FFFF;
    run_txn(4'h2, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
    check("op_count_wrap", 64'(op_count), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
